// File: rtl/axis_stall_detector.sv
// Per-channel AXI-Stream stall detector: flags channels stalled for THRESH
// consecutive cycles, latches the first channel to block, counts block episodes.
module axis_stall_detector #(
  parameter int NUM_CH = 4,
  parameter int THRESH = 16,
  parameter int CNT_W  = 8,
  parameter int IDX_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] rd_req,
  input  logic [NUM_CH-1:0] rd_empty,
  input  logic [NUM_CH-1:0] wr_req,
  input  logic [NUM_CH-1:0] wr_full,
  input  logic              clear_latch,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              block_any,
  output logic              first_valid,
  output logic [IDX_W-1:0]  first_idx,
  output logic [15:0]       event_cnt
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  typedef enum logic {
    LATCH_IDLE,
    LATCH_CAPTURED
  } latch_state_e;

  logic [NUM_CH-1:0]            stall;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            block_prev_q, block_prev_d;
  logic [NUM_CH-1:0]            block_rise;
  logic                         block_any_prev_q, block_any_prev_d;
  latch_state_e                 state_q, state_d;
  logic                         first_valid_q, first_valid_d;
  logic [IDX_W-1:0]             first_idx_q, first_idx_d;
  logic [15:0]                  event_cnt_q, event_cnt_d;
  logic [IDX_W-1:0]             rise_idx;

  assign stall = (rd_req & rd_empty) | (wr_req & wr_full);

  // Block flags decode the registered counters, so they never glitch.
  always_comb begin
    axis_block_sigs = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      axis_block_sigs[i] = (cnt_q[i] == THRESH_C);
    end
  end

  assign block_any  = |axis_block_sigs;
  assign block_rise = axis_block_sigs & ~block_prev_q;

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!enable || !stall[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < THRESH_C) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Descending scan so the lowest rising index is the one that sticks.
  always_comb begin
    rise_idx = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (block_rise[i-1]) begin
        rise_idx = IDX_W'(i - 1);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    first_valid_d = first_valid_q;
    first_idx_d   = first_idx_q;
    if (clear_latch) begin
      state_d       = LATCH_IDLE;
      first_valid_d = 1'b0;
      first_idx_d   = '0;
    end else begin
      case (state_q)
        LATCH_IDLE: begin
          if (|block_rise) begin
            state_d       = LATCH_CAPTURED;
            first_valid_d = 1'b1;
            first_idx_d   = rise_idx;
          end
        end
        LATCH_CAPTURED: ;
        default: begin
          state_d       = LATCH_IDLE;
          first_valid_d = 1'b0;
          first_idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    block_prev_d     = axis_block_sigs;
    block_any_prev_d = block_any;
    event_cnt_d      = event_cnt_q;
    if (block_any && !block_any_prev_q && (event_cnt_q != '1)) begin
      event_cnt_d = event_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q            <= '0;
      block_prev_q     <= '0;
      block_any_prev_q <= 1'b0;
      state_q          <= LATCH_IDLE;
      first_valid_q    <= 1'b0;
      first_idx_q      <= '0;
      event_cnt_q      <= '0;
    end else begin
      cnt_q            <= cnt_d;
      block_prev_q     <= block_prev_d;
      block_any_prev_q <= block_any_prev_d;
      state_q          <= state_d;
      first_valid_q    <= first_valid_d;
      first_idx_q      <= first_idx_d;
      event_cnt_q      <= event_cnt_d;
    end
  end

  assign first_valid = first_valid_q;
  assign first_idx   = first_idx_q;
  assign event_cnt   = event_cnt_q;

endmodule
